// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP sequencer: FSM states, FP op encodings
// and the latency counter width.
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_SUB = 2'b01;
  localparam logic [1:0] FP_MUL = 2'b10;
  localparam logic [1:0] FP_DIV = 2'b11;

  localparam int CNT_W = 8;

endpackage

// File: rtl/fp_seq_ctrl.sv
// Issues FP add/sub/mul/div to the shared FP unit one at a time, times the
// fixed latency, stalls Decode while busy and strobes the FP writeback.
module fp_seq_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IsFpD,
  input  logic [1:0] FpOpD,
  input  logic [4:0] RdD,
  input  logic       StallD,
  input  logic       FlushE,
  output logic       StallFpD,
  output logic       FpStartE,
  output logic [1:0] FpOpE,
  output logic       FpBusy,
  output logic       FpWeW,
  output logic [4:0] FpRdW,
  output logic [1:0] DbgState
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [1:0]         r_op;
  logic [4:0]         r_rd;
  logic               r_start;
  logic               w_issue;

  // Count is loaded with LAT-1 so that RUN lasts exactly LAT cycles.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      FP_MUL:  lat_m1 = CNT_W'(MUL_LAT - 1);
      FP_DIV:  lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(ADD_LAT - 1);
    endcase
  endfunction

  // Stall depends only on IsFpD and state, never on StallD/FlushE,
  // so there is no combinational loop through the hazard unit.
  assign StallFpD = IsFpD & (r_state == RUN);
  assign w_issue  = IsFpD & ~StallD & ~FlushE & ~StallFpD & (r_state != RUN);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_next = RUN;
          w_count_next = lat_m1(FpOpD);
        end
      end
      RUN: begin
        if (r_count == '0) begin
          w_state_next = DONE;
        end else begin
          w_count_next = r_count - 1'b1;
        end
      end
      DONE: begin
        if (w_issue) begin
          w_state_next = RUN;
          w_count_next = lat_m1(FpOpD);
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_op    <= FP_ADD;
      r_rd    <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_start <= w_issue;
      if (w_issue) begin
        r_op <= FpOpD;
        r_rd <= RdD;
      end
    end
  end

  assign FpStartE = r_start;
  assign FpOpE    = r_op;
  assign FpBusy   = (r_state == RUN);
  assign FpWeW    = (r_state == DONE);
  assign FpRdW    = (r_state == DONE) ? r_rd : 5'd0;
  assign DbgState = r_state;

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Directed bench for fp_seq_ctrl: two instances (default latencies and
// ADD_LAT=1) share stimulus and are checked every cycle against a timeline model.
module tb_fp_seq_ctrl;
  import fp_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       IsFpD = 1'b0;
  logic [1:0] FpOpD = 2'b00;
  logic [4:0] RdD = 5'd0;
  logic       StallD = 1'b0;
  logic       FlushE = 1'b0;

  logic       o_stall [2];
  logic       o_start [2];
  logic [1:0] o_op    [2];
  logic       o_busy  [2];
  logic       o_we    [2];
  logic [4:0] o_rd    [2];
  logic [1:0] o_dbg   [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_seq_ctrl u0 (
    .clk(clk), .reset(reset), .IsFpD(IsFpD), .FpOpD(FpOpD), .RdD(RdD),
    .StallD(StallD), .FlushE(FlushE), .StallFpD(o_stall[0]), .FpStartE(o_start[0]),
    .FpOpE(o_op[0]), .FpBusy(o_busy[0]), .FpWeW(o_we[0]), .FpRdW(o_rd[0]),
    .DbgState(o_dbg[0])
  );

  fp_seq_ctrl #(.ADD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .IsFpD(IsFpD), .FpOpD(FpOpD), .RdD(RdD),
    .StallD(StallD), .FlushE(FlushE), .StallFpD(o_stall[1]), .FpStartE(o_start[1]),
    .FpOpE(o_op[1]), .FpBusy(o_busy[1]), .FpWeW(o_we[1]), .FpRdW(o_rd[1]),
    .DbgState(o_dbg[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d] cyc=%0d got=%0h expected=%0h", name, k, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each op occupies the unit for LAT cycles after the issue cycle, then one
  // writeback cycle; only the last issue's timeline matters.
  int         m_issue [2] = '{-1000, -1000};
  int         m_lat   [2] = '{1, 1};
  logic [1:0] m_op    [2] = '{2'b00, 2'b00};
  logic [4:0] m_rd    [2] = '{5'd0, 5'd0};

  function automatic int lat_of(input int k, input logic [1:0] op);
    if (op == FP_DIV) return 16;
    if (op == FP_MUL) return 3;
    return (k == 0) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_issue[k] = -1000;
        m_op[k]    = 2'b00;
        m_rd[k]    = 5'd0;
        chk("rst_stall", k, 32'(o_stall[k]), 0);
        chk("rst_start", k, 32'(o_start[k]), 0);
        chk("rst_busy",  k, 32'(o_busy[k]),  0);
        chk("rst_we",    k, 32'(o_we[k]),    0);
        chk("rst_op",    k, 32'(o_op[k]),    0);
        chk("rst_rd",    k, 32'(o_rd[k]),    0);
      end else begin
        automatic bit run = (cyc >= m_issue[k] + 1) && (cyc <= m_issue[k] + m_lat[k]);
        automatic bit wb  = (cyc == m_issue[k] + m_lat[k] + 1);
        automatic state_t st = run ? RUN : (wb ? DONE : IDLE);
        chk("stall", k, 32'(o_stall[k]), 32'(IsFpD & run));
        chk("start", k, 32'(o_start[k]), 32'(cyc == m_issue[k] + 1));
        chk("busy",  k, 32'(o_busy[k]),  32'(run));
        chk("we",    k, 32'(o_we[k]),    32'(wb));
        chk("op",    k, 32'(o_op[k]),    32'(m_op[k]));
        if (wb) chk("rd", k, 32'(o_rd[k]), 32'(m_rd[k]));
        chk("state", k, 32'(o_dbg[k]),   32'(st));
        if (IsFpD && !StallD && !FlushE && !run) begin
          m_issue[k] = cyc;
          m_lat[k]   = lat_of(k, FpOpD);
          m_op[k]    = FpOpD;
          m_rd[k]    = RdD;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic nxt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    nxt(3);

    // add to f7: start T+1, busy T+1..T+2, writeback T+3 (u1: T+2)
    IsFpD = 1; FpOpD = FP_ADD; RdD = 5'd7;
    nxt(1); IsFpD = 0;
    @(negedge clk);
    chk("add_start", 0, 32'(o_start[0]), 1);
    chk("add_busy1", 0, 32'(o_busy[0]), 1);
    nxt(1); @(negedge clk);
    chk("add_busy2", 0, 32'(o_busy[0]), 1);
    chk("add_we_u1", 1, 32'(o_we[1]), 1);
    nxt(1); @(negedge clk);
    chk("add_we",    0, 32'(o_we[0]), 1);
    chk("add_rd",    0, 32'(o_rd[0]), 7);
    nxt(2);

    // div to f3 with a mul to f5 held in Decode behind it
    IsFpD = 1; FpOpD = FP_DIV; RdD = 5'd3;
    nxt(1); FpOpD = FP_MUL; RdD = 5'd5;
    @(negedge clk);
    chk("div_stall_first", 0, 32'(o_stall[0]), 1);
    nxt(15); @(negedge clk);
    chk("div_stall_last", 0, 32'(o_stall[0]), 1);
    nxt(1); @(negedge clk);
    chk("div_we",    0, 32'(o_we[0]), 1);
    chk("div_rd",    0, 32'(o_rd[0]), 3);
    chk("div_nostall", 0, 32'(o_stall[0]), 0);
    nxt(1); IsFpD = 0;
    @(negedge clk);
    chk("b2b_start", 0, 32'(o_start[0]), 1);
    chk("b2b_op",    0, 32'(o_op[0]), 2);
    nxt(3); @(negedge clk);
    chk("b2b_we",    0, 32'(o_we[0]), 1);
    chk("b2b_rd",    0, 32'(o_rd[0]), 5);
    nxt(2);

    // flush then stall gating
    IsFpD = 1; FpOpD = FP_ADD; RdD = 5'd9; FlushE = 1;
    nxt(3); FlushE = 0; StallD = 1;
    nxt(3); StallD = 0; IsFpD = 0;
    @(negedge clk);
    chk("gate_start", 0, 32'(o_start[0]), 0);
    chk("gate_state", 0, 32'(o_dbg[0]), 32'(IDLE));
    nxt(4);

    // mul in flight under integer traffic
    IsFpD = 1; FpOpD = FP_MUL; RdD = 5'd12;
    nxt(1); IsFpD = 0;
    for (int i = 0; i < 20; i++) begin
      StallD = 1'($urandom_range(0, 1));
      FlushE = 1'($urandom_range(0, 1));
      FpOpD  = 2'($urandom_range(0, 3));
      RdD    = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("int_stall", 0, 32'(o_stall[0]), 0);
      if (i == 3) begin
        chk("int_we", 0, 32'(o_we[0]), 1);
        chk("int_rd", 0, 32'(o_rd[0]), 12);
      end
      nxt(1);
    end
    StallD = 0; FlushE = 0;
    nxt(2);

    // asynchronous reset in the middle of a div
    IsFpD = 1; FpOpD = FP_DIV; RdD = 5'd20;
    nxt(1); IsFpD = 0;
    nxt(5);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy",  0, 32'(o_busy[0]), 0);
    chk("arst_we",    0, 32'(o_we[0]), 0);
    chk("arst_state", 0, 32'(o_dbg[0]), 32'(IDLE));
    nxt(2); reset = 1'b0;
    nxt(20);

    // ADD_LAT=1 corner on u1: sub to f31
    IsFpD = 1; FpOpD = FP_SUB; RdD = 5'd31;
    nxt(1); IsFpD = 0;
    @(negedge clk);
    chk("lat1_start", 1, 32'(o_start[1]), 1);
    chk("lat1_busy",  1, 32'(o_busy[1]), 1);
    nxt(1); @(negedge clk);
    chk("lat1_we",    1, 32'(o_we[1]), 1);
    chk("lat1_rd",    1, 32'(o_rd[1]), 31);
    chk("lat1_u0_we", 0, 32'(o_we[0]), 0);
    nxt(3);

    // mixed traffic
    for (int i = 0; i < 300; i++) begin
      IsFpD  = 1'($urandom_range(0, 1));
      FpOpD  = 2'($urandom_range(0, 3));
      RdD    = 5'($urandom_range(0, 31));
      StallD = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 5) == 0);
      nxt(1);
    end
    IsFpD = 0; StallD = 0; FlushE = 0;
    nxt(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_seq_ctrl.md
# fp_seq_ctrl

Multi-cycle sequencer for the shared floating-point execution unit in the pipelined RV32 core. It accepts FP arithmetic instructions (add, sub, mul, div) as they leave Decode and issues them to the FP unit one at a time. It times each operation's fixed latency and stalls Decode while the unit is occupied. It then produces a one-cycle writeback strobe with the destination register for the FP register file.

## Interface
- ADD_LAT, 2, cycles from start to valid result for add/sub (≥1)
- MUL_LAT, 3, cycles for mul (≥1)
- DIV_LAT, 16, cycles for div (≥1, ≤255)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- IsFpD  in  1  instruction in Decode is FP arithmetic
- FpOpD  in  2  op in Decode: 00 add, 01 sub, 10 mul, 11 div
- RdD  in  5  FP destination register in Decode
- StallD  in  1  Decode stalled by the integer hazard unit
- FlushE  in  1  ID/EX flush; the Decode instruction is squashed
- StallFpD  out  1  stall request to Decode/Fetch (combinational)
- FpStartE  out  1  one-cycle start pulse to the FP unit (registered)
- FpOpE  out  2  latched op presented to the FP unit, stable while busy
- FpBusy  out  1  high in RUN
- FpWeW  out  1  one-cycle FP register-file write enable
- FpRdW  out  5  destination register, valid when FpWeW=1

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, count=0, FpOpE=00, FpRdW=0, and all strobes to 0.
- Issue condition: IsFpD & !StallD & !FlushE & !StallFpD.
- Issue action, legal in IDLE or DONE:
  - latch FpOpE←FpOpD and RdQ←RdD
  - load count←LAT(op)−1
  - next state RUN; FpStartE=1 in the next cycle only
- LAT(op): 00/01→ADD_LAT, 10→MUL_LAT, 11→DIV_LAT. Count is 8 bits, unsigned.
- RUN: if count==0 go to DONE, else count←count−1. Issue is illegal in RUN.
- DONE:
  - FpWeW=1 and FpRdW=RdQ for exactly this cycle
  - with a valid issue, go to RUN (back-to-back); otherwise go to IDLE
- StallFpD = IsFpD & (state==RUN). Non-FP instructions never stall here.
- FlushE or StallD in the issue cycle suppresses issue entirely: no state change, no latch.
- In-flight ops are never cancelled. By the time an op is in RUN it is older than any branch resolving in Execute.
- The FP unit holds its result from start+LAT until the next FpStartE. The FP register file is write-before-read, so Decode reading RdQ during DONE needs no stall.
- Asynchronous reset mid-RUN or in DONE discards the op: no FpWeW is produced and the state returns to IDLE immediately.

## Timing
- Issue sampled in cycle T → RUN during T+1..T+LAT, FpStartE high in T+1, DONE (FpWeW) in T+LAT+1.
- Issue-to-writeback latency is LAT+1 cycles. Peak throughput is one op per LAT+1 cycles.
- A back-to-back op issued in DONE at T+LAT+1 gets its FpStartE in T+LAT+2.
- StallFpD is combinational from IsFpD and state, with no dependence on StallD or FlushE, so there is no loop through the hazard unit.
- LAT=1: a single RUN cycle (count loaded 0), DONE the cycle after.

## Structure
- Shared package fp_ctrl_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - FP op encodings FP_ADD=2'b00, FP_SUB=2'b01, FP_MUL=2'b10, FP_DIV=2'b11
  - count width localparam (8)
- Single module with no sub-module. The latency select is a small inline function; the down-counter and FSM are inline.

## Test plan
- Add: IsFpD=1, FpOpD=00, RdD=7 at cycle 10 → FpStartE at 11, FpBusy 11–12, FpWeW=1 with FpRdW=7 at 13 only.
- Div plus contention: div to f3 at cycle 5, second FP op held in Decode → StallFpD=1 cycles 6–21, FpWeW at 22. The held op issues in 22, gets FpStartE at 23, and its FpWeW follows at 23+LAT(op).
- Flush/stall gating: IsFpD=1 with FlushE=1 (repeat with StallD=1) → no FpStartE, state stays IDLE, FpWeW never asserts.
- Integer traffic: IsFpD=0 for 20 cycles during a mul in flight → StallFpD stays 0 throughout, and a single FpWeW occurs at issue+4.
- Reset mid-div: assert reset at issue+6 → all outputs 0 asynchronously; after release, state is IDLE and no FpWeW appears.
- Parameter corner: ADD_LAT=1, sub to f31 at cycle 2 → FpStartE at 3, FpWeW with FpRdW=31 at 4.
